// File: rtl/posit_ppu_if.sv
// Posit processing unit request/response bundle.
//   ppu_valid_in : request strobe; operands and op held stable while high
//   ppu_in1/2    : N-bit posit operands A and B
//   ppu_op       : 0=ADD, 1=SUB, 2=MUL, others reserved
//   ppu_out      : registered N-bit posit result
//   ppu_valid_o  : one-cycle completion pulse
// master = execute stage (requester), slave = posit_ppu.
interface posit_ppu_if #(
  parameter int N        = 16,
  parameter int OP_WIDTH = 3
);
  logic                ppu_valid_in;
  logic [N-1:0]        ppu_in1;
  logic [N-1:0]        ppu_in2;
  logic [OP_WIDTH-1:0] ppu_op;
  logic [N-1:0]        ppu_out;
  logic                ppu_valid_o;

  modport master (
    output ppu_valid_in, ppu_in1, ppu_in2, ppu_op,
    input  ppu_out, ppu_valid_o
  );

  modport slave (
    input  ppu_valid_in, ppu_in1, ppu_in2, ppu_op,
    output ppu_out, ppu_valid_o
  );
endinterface

// File: rtl/posit_ppu.sv
// Posit processing unit: ADD / SUB / MUL of two N-bit posits with ES exponent
// bits, round-to-nearest-even on the final bit pattern, saturating to
// maxpos/minpos. One operation is computed combinationally on accept and
// registered; the unit then spends one DONE cycle pulsing ppu_valid_o.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (clears result, returns to IDLE)
//   bus  : posit_ppu_if.slave (valid_in, in1, in2, op -> out, valid_o)
module posit_ppu #(
  parameter int N        = 16,
  parameter int ES       = 1,
  parameter int OP_WIDTH = 3
) (
  input logic        clk,
  input logic        rst,
  posit_ppu_if.slave bus
);
  // Normalised mantissa: hidden one at MSB. N+3 bits below the operand
  // significand leave guard room so alignment loss only reaches the LSB.
  localparam int MW = 2 * N + 4;
  localparam int SW = $clog2(N) + ES + 6;
  localparam int LW = 2 + ES + (MW - 1) + N;

  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(2);

  typedef struct packed {
    logic                 sgn;
    logic                 zero;
    logic                 nar;
    logic signed [SW-1:0] scale;
    logic [N-1:0]         sig;   // 1.f, N-1 fraction bits
  } dec_t;

  typedef enum logic {IDLE, DONE} state_t;

  function automatic dec_t decode(input logic [N-1:0] p);
    dec_t         d;
    logic [N-2:0] body;
    logic [N-2:0] rem;
    logic [N-2:0] e_bits;
    logic         r0;
    logic         run;
    int           m;
    int           k;
    d.sgn  = p[N-1];
    d.zero = (p == '0);
    d.nar  = (p == NAR);
    body   = (N-1)'(p[N-1] ? -p : p);
    r0     = body[N-2];
    run    = 1'b1;
    m      = 0;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (body[i] == r0)) m++;
      else run = 1'b0;
    end
    k       = r0 ? m - 1 : -m;
    // Drop regime and its terminator; exponent then fraction remain left-aligned.
    rem     = body << (m + 1);
    e_bits  = rem >> (N - 1 - ES);
    d.scale = SW'(k * (1 << ES) + int'(e_bits));
    d.sig   = {1'b1, rem << ES};
    return d;
  endfunction

  function automatic logic [N-2:0] round_rne(input logic [N-2:0] b, input logic g,
                                             input logic s);
    return b + (N-1)'(g & (s | b[0]));
  endfunction

  function automatic logic [N-2:0] saturate(input int k, input logic [N-2:0] body);
    if (k > N - 3) return '1;            // above maxpos
    if (k < 2 - N) return (N-1)'(1);     // nonzero but below minpos
    return body;
  endfunction

  function automatic logic [N-1:0] encode(input logic sgn, input logic signed [SW-1:0] scale,
                                          input logic [MW-1:0] mant);
    logic [LW-1:0] v;
    logic [1:0]    r_pat;
    logic [N-2:0]  body;
    int            k;
    int            e;
    int            sh;
    if (!mant[MW-1]) return '0;
    k  = int'(scale) >>> ES;
    e  = int'(scale) - k * (1 << ES);
    // Arithmetic shift of "10" yields k+1 ones then 0; of "01" yields -k zeros then 1.
    r_pat = (k >= 0) ? 2'b10 : 2'b01;
    sh    = (k >= 0) ? k : -k - 1;
    v = {r_pat, {(LW-2){1'b0}}}
      | (LW'(e) << (LW - 2 - ES))
      | (LW'(mant[MW-2:0]) << N);
    v = LW'($signed(v) >>> sh);
    body = round_rne(v[LW-1 -: N-1], v[LW-N], |v[LW-N-1:0]);
    body = saturate(k, body);
    return sgn ? -{1'b0, body} : {1'b0, body};
  endfunction

  function automatic logic [N-1:0] posit_add(input logic [N-1:0] pa, input logic [N-1:0] pb,
                                             input logic sub);
    dec_t          a;
    dec_t          b;
    dec_t          big;
    dec_t          sml;
    logic [MW-1:0] x;
    logic [MW-1:0] y;
    logic [MW-1:0] mask;
    logic [MW-1:0] s;
    logic          swap;
    logic          lost;
    int            d;
    int            p;
    a = decode(pa);
    b = decode(pb);
    if (a.nar || b.nar) return NAR;
    if (b.zero) return pa;
    if (a.zero) return sub ? -pb : pb;
    b.sgn = b.sgn ^ sub;
    swap  = (b.scale > a.scale) || ((b.scale == a.scale) && (b.sig > a.sig));
    big   = swap ? b : a;
    sml   = swap ? a : b;
    d     = int'(big.scale) - int'(sml.scale);
    x     = {1'b0, big.sig, {(N+3){1'b0}}};
    y     = {1'b0, sml.sig, {(N+3){1'b0}}};
    if (d >= MW) begin
      lost = |y;
      y    = '0;
    end else begin
      mask = (MW'(1) << d) - MW'(1);
      lost = |(y & mask);
      y    = y >> d;
    end
    // Bits shifted out lie far below the rounding point; folding them into
    // the LSB keeps both sticky and subtraction borrow correct.
    y[0] = y[0] | lost;
    s    = (big.sgn == sml.sgn) ? x + y : x - y;
    if (s == '0) return '0;
    p = 0;
    for (int i = 0; i < MW; i++) if (s[i]) p = i;
    s = s << (MW - 1 - p);
    return encode(big.sgn, SW'(int'(big.scale) + p - (MW - 2)), s);
  endfunction

  function automatic logic [N-1:0] posit_mul(input logic [N-1:0] pa, input logic [N-1:0] pb);
    dec_t           a;
    dec_t           b;
    logic [2*N-1:0] prod;
    int             sc;
    a = decode(pa);
    b = decode(pb);
    if (a.nar || b.nar) return NAR;
    if (a.zero || b.zero) return '0;
    prod = (2*N)'(a.sig) * (2*N)'(b.sig);
    sc   = int'(a.scale) + int'(b.scale) + (prod[2*N-1] ? 1 : 0);
    if (!prod[2*N-1]) prod = prod << 1;
    return encode(a.sgn ^ b.sgn, SW'(sc), {prod, 4'b0000});
  endfunction

  state_t       state_q;
  state_t       state_d;
  logic         accept;
  logic [N-1:0] result_p0;

  always_comb begin
    state_d = IDLE;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ppu_valid_in) begin
          state_d = DONE;
          accept  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (bus.ppu_op)
      OP_ADD:  result_p0 = posit_add(bus.ppu_in1, bus.ppu_in2, 1'b0);
      OP_SUB:  result_p0 = posit_add(bus.ppu_in1, bus.ppu_in2, 1'b1);
      OP_MUL:  result_p0 = posit_mul(bus.ppu_in1, bus.ppu_in2);
      default: result_p0 = '0;
    endcase
  end

  // p0 -> output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus.ppu_out <= '0;
    end else begin
      state_q <= state_d;
      if (accept) bus.ppu_out <= result_p0;
    end
  end

  assign bus.ppu_valid_o = (state_q == DONE);
endmodule

// File: tb/tb_posit_ppu.sv
module tb_posit_ppu;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  posit_ppu_if #(.N(N), .OP_WIDTH(3)) bus ();

  posit_ppu #(.N(N), .ES(1), .OP_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [N-1:0] exp_q[$];
  string        name_q[$];

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: every completion pulse pops one expected result.
  always @(negedge clk) begin
    if (bus.ppu_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got out %h want no pulse", bus.ppu_out);
      end else begin
        check(name_q.pop_front(), bus.ppu_out, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2:0] op, input logic [N-1:0] e);
    @(negedge clk);
    bus.ppu_in1      = a;
    bus.ppu_in2      = b;
    bus.ppu_op       = op;
    bus.ppu_valid_in = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    bus.ppu_valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst              = 1'b1;
    bus.ppu_valid_in = 1'b1;
    bus.ppu_in1      = 16'h4000;
    bus.ppu_in2      = 16'h4000;
    bus.ppu_op       = 3'd0;
    repeat (2) begin
      @(negedge clk);
      check("rst_out", bus.ppu_out, 16'h0000);
      check("rst_vld", N'(bus.ppu_valid_o), 16'h0000);
    end
    // Release with the request still held: pulse exactly one cycle later.
    rst = 1'b0;
    exp_q.push_back(16'h5000);
    name_q.push_back("first_after_rst");
    @(negedge clk);
    check("first_pulse", N'(bus.ppu_valid_o), 16'h0001);
    bus.ppu_valid_in = 1'b0;

    run_op("add_1_1",      16'h4000, 16'h4000, 3'd0, 16'h5000);
    run_op("add_1_2",      16'h4000, 16'h5000, 3'd0, 16'h5800);
    run_op("add_cancel",   16'h4000, 16'hC000, 3'd0, 16'h0000);
    run_op("add_2_m1",     16'h5000, 16'hC000, 3'd0, 16'h4000);
    run_op("add_neg_neg",  16'hC000, 16'hC000, 3'd0, 16'hB000);
    run_op("sub_2_1",      16'h5000, 16'h4000, 3'd1, 16'h4000);
    run_op("sub_1_2",      16'h4000, 16'h5000, 3'd1, 16'hC000);
    run_op("sub_self",     16'h5000, 16'h5000, 3'd1, 16'h0000);
    run_op("sub_zero_a",   16'h0000, 16'h4000, 3'd1, 16'hC000);
    run_op("add_zero_b",   16'h5800, 16'h0000, 3'd0, 16'h5800);
    run_op("mul_2_2",      16'h5000, 16'h5000, 3'd2, 16'h6000);
    run_op("mul_neg",      16'h4000, 16'hC000, 3'd2, 16'hC000);
    run_op("mul_half_2",   16'h3000, 16'h5000, 3'd2, 16'h4000);
    run_op("mul_maxpos",   16'h7FFF, 16'h7FFF, 3'd2, 16'h7FFF);
    run_op("mul_negmax",   16'h8001, 16'h7FFF, 3'd2, 16'h8001);
    run_op("mul_minpos",   16'h0001, 16'h0001, 3'd2, 16'h0001);
    run_op("mul_zero",     16'h4000, 16'h0000, 3'd2, 16'h0000);
    run_op("add_nar",      16'h8000, 16'h4000, 3'd0, 16'h8000);
    run_op("mul_zero_nar", 16'h0000, 16'h8000, 3'd2, 16'h8000);
    run_op("reserved_op",  16'h4000, 16'h4000, 3'd5, 16'h0000);
    run_op("add_tie_even", 16'h4001, 16'h4000, 3'd0, 16'h5000);
    run_op("mul_round_dn", 16'h4001, 16'h4001, 3'd2, 16'h4002);

    // Request held for four edges: accepts on the 1st and 3rd only.
    @(negedge clk);
    bus.ppu_in1      = 16'h4000;
    bus.ppu_in2      = 16'h4000;
    bus.ppu_op       = 3'd0;
    bus.ppu_valid_in = 1'b1;
    repeat (2) begin
      exp_q.push_back(16'h5000);
      name_q.push_back("hold_add");
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_vld", N'(bus.ppu_valid_o), (i % 2 == 0) ? 16'h0001 : 16'h0000);
    end
    bus.ppu_valid_in = 1'b0;

    // Operand changes while idle must not disturb the held result.
    bus.ppu_in1 = 16'h7FFF;
    bus.ppu_in2 = 16'h7FFF;
    bus.ppu_op  = 3'd2;
    repeat (3) begin
      @(negedge clk);
      check("idle_out", bus.ppu_out, 16'h5000);
      check("idle_vld", N'(bus.ppu_valid_o), 16'h0000);
    end

    // Reset in the accept cycle discards the request.
    @(negedge clk);
    bus.ppu_in1      = 16'h5000;
    bus.ppu_in2      = 16'h5000;
    bus.ppu_op       = 3'd0;
    bus.ppu_valid_in = 1'b1;
    rst              = 1'b1;
    @(negedge clk);
    rst              = 1'b0;
    bus.ppu_valid_in = 1'b0;
    check("rst_acc_out", bus.ppu_out, 16'h0000);
    repeat (2) begin
      @(negedge clk);
      check("rst_acc_vld", N'(bus.ppu_valid_o), 16'h0000);
    end

    // Drain: every expected result must have been observed.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/posit_ppu.md
# posit_ppu

Posit Processing Unit: a single-operation posit arithmetic engine that adds, subtracts or multiplies two N-bit posits (ES exponent bits) and returns a correctly rounded posit. It sits in the execute stage beside the integer ALU and multiplier/divider. The EX stage drives operands and an operation code with a valid flag, and holds them until the unit pulses its done flag. One instance serves a full 32-bit word, or several instances each serve an N-bit lane of a packed word.

## Interface
- N, default 16: posit width in bits (one 32-bit lane uses 32; SIMD lanes use 32/lane count).
- ES, default 1: exponent field width.
- OP_WIDTH, default 3: width of ppu_op.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- ppu_valid_in  in  1  operation request; operands/op stable while high.
- ppu_in1  in  N  posit operand A.
- ppu_in2  in  N  posit operand B.
- ppu_op  in  OP_WIDTH  0=ADD (A+B), 1=SUB (A−B), 2=MUL (A·B), 3..7 reserved.
- ppu_out  out  N  registered result posit.
- ppu_valid_o  out  1  one-cycle pulse: ppu_out holds the result of the accepted operation.

## Operation
- Encoding: bit N−1 = sign; negative values are two's complement of the magnitude pattern. Regime = run of identical bits after sign, terminated by the opposite bit or word end; run of m ones → k=m−1, m zeros → k=−m. Then up to ES exponent bits (missing bits = 0), then fraction with hidden 1. Value = (−1)^s · 2^(k·2^ES + e) · 1.f.
- Specials: 0x0…0 = zero; 1 followed by zeros = NaR.
- Decode both operands to sign, scale (signed, k·2^ES+e), significand; compute exactly (ADD/SUB: align by scale difference, keep guard+sticky; MUL: full significand product, add scales); normalise; encode.
- Rounding: round-to-nearest, ties-to-even, on the final N-bit pattern using guard/sticky bits beyond the last kept bit (regime length reduces available fraction/exponent bits).
- Saturation: magnitude above maxpos → maxpos (0x7F…F, or its negation); nonzero magnitude below minpos → minpos (0x0…01, or its negation). Nonzero results never round to zero or NaR.
- Special rules: any NaR operand → NaR. ADD/SUB with zero returns the other operand (negated for 0−B). Exact cancellation → zero. MUL by zero → zero (unless NaR involved). Result of exactly zero is always +0.
- Reserved ops: result 0, ppu_valid_o still pulses.
- Two states: IDLE, DONE. IDLE & ppu_valid_in → compute combinationally, register ppu_out, go DONE. DONE: ppu_valid_o=1 for that cycle; ppu_valid_in ignored; return to IDLE unconditionally.
- ppu_out holds the last result until the next completion.

## Timing
- Reset: ppu_out=0, ppu_valid_o=0, state IDLE; reset in any cycle (including DONE or accept cycle) discards pending work; ppu_valid_o=0 in the cycle after reset deasserts until a new accept.
- Latency: request sampled at edge t in IDLE → ppu_out/ppu_valid_o valid in cycle t+1.
- Throughput: one op per 2 cycles; ppu_valid_in held continuously → accept every other edge, ppu_valid_o alternates 1,0,1,0 starting one cycle after first accept.
- Holding ppu_valid_in high during the DONE cycle (requester still stalled on same op) must not re-launch the op.
- Operand changes while ppu_valid_in=0 have no effect on outputs.

## Test plan
- Reset: rst=1 two cycles with ppu_valid_in=1 → ppu_out=0x0000, ppu_valid_o=0; release rst → first pulse exactly one cycle after first sampled request.
- ADD (N=16,ES=1): 0x4000+0x4000 → 0x5000; 0x4000+0x5000 → 0x5800; 0x4000+0xC000 → 0x0000.
- SUB/MUL: 0x5000−0x4000 → 0x4000; 0x5000·0x5000 → 0x6000; 0x4000·0xC000 → 0xC000; 0x3000·0x5000 → 0x4000.
- Saturation/specials: 0x7FFF·0x7FFF → 0x7FFF; 0x0001·0x0001 → 0x0001; 0x8000+0x4000 → 0x8000; 0x0000·0x8000 → 0x8000; op=5 → 0x0000 with pulse.
- Rounding: 0x4001+0x4000 (ties case at 2.0 region) → 0x5000 (even); compare random ops against a software posit reference with RNE.
- Handshake: ppu_valid_in held 4 cycles with fixed ADD 1+1 → ppu_valid_o pulses in cycles 1 and 3 only, ppu_out=0x5000; rst asserted in accept cycle → no pulse follows.
